// File: rtl/enemy_unit.sv
// Single enemy unit: spawns on request, advances toward the opposing front line,
// attacks on a cooldown when blocked, takes damage and dies after a fixed hold.
module enemy_unit #(
  parameter int POS_W     = 9,
  parameter int DMG_W     = 8,
  parameter int HP_W      = 8,
  parameter int COOLDOWN  = 4,
  parameter int DEAD_HOLD = 10,
  parameter int START_POS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spawn_req,
  input  logic [1:0]       spawn_type,
  output logic             spawn_ready,
  input  logic             move_en,
  input  logic             damage_en,
  input  logic [DMG_W-1:0] damage_in,
  input  logic [POS_W-1:0] unit_front,
  output logic [POS_W-1:0] position,
  output logic [DMG_W-1:0] damage_out,
  output logic [1:0]       enemy_type,
  output logic             alive,
  output logic             dead
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPAWN = 2'd1,
    ALIVE = 2'd2,
    DYING = 2'd3
  } state_t;

  localparam int CD_W   = $clog2(COOLDOWN + 2);
  localparam int HOLD_W = $clog2(DEAD_HOLD + 2);
  localparam int CMP_W  = (DMG_W > HP_W) ? DMG_W : HP_W;

  state_t           state_r, state_s;
  logic [1:0]       type_lat_r, type_lat_s;
  logic [1:0]       etype_r, etype_s;
  logic [POS_W-1:0] pos_r, pos_s;
  logic [HP_W-1:0]  health_r, health_s;
  logic [DMG_W-1:0] power_r, power_s;
  logic [DMG_W-1:0] dmg_out_r, dmg_out_s;
  logic [CD_W-1:0]  cd_r, cd_s;
  logic [HOLD_W-1:0] hold_r, hold_s;

  logic [CMP_W-1:0] hp_ext_s, dmg_ext_s, hp_diff_s;
  logic             kill_s, advance_s;

  // Attack strength doubles with each unit type step.
  function automatic logic [DMG_W-1:0] power_f(input logic [1:0] t);
    power_f = DMG_W'(1) << (DMG_W - 4 + int'(t));
  endfunction

  assign hp_ext_s  = CMP_W'(health_r);
  assign dmg_ext_s = CMP_W'(damage_in);
  assign hp_diff_s = hp_ext_s - dmg_ext_s;
  assign kill_s    = damage_en && (dmg_ext_s >= hp_ext_s);
  assign advance_s = (pos_r < unit_front) && (pos_r != {POS_W{1'b1}});

  assign spawn_ready = (state_r == IDLE);
  assign alive       = (state_r == ALIVE);
  assign dead        = (state_r == DYING);
  assign position    = pos_r;
  assign damage_out  = dmg_out_r;
  assign enemy_type  = etype_r;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      type_lat_r <= 2'd0;
      etype_r    <= 2'd0;
      pos_r      <= POS_W'(START_POS);
      health_r   <= {HP_W{1'b0}};
      power_r    <= {DMG_W{1'b0}};
      dmg_out_r  <= {DMG_W{1'b0}};
      cd_r       <= {CD_W{1'b0}};
      hold_r     <= {HOLD_W{1'b0}};
    end else begin
      state_r    <= state_s;
      type_lat_r <= type_lat_s;
      etype_r    <= etype_s;
      pos_r      <= pos_s;
      health_r   <= health_s;
      power_r    <= power_s;
      dmg_out_r  <= dmg_out_s;
      cd_r       <= cd_s;
      hold_r     <= hold_s;
    end
  end

  // Next-state and datapath update; damage_out is a pulse, so it defaults to zero.
  always_comb begin
    state_s    = state_r;
    type_lat_s = type_lat_r;
    etype_s    = etype_r;
    pos_s      = pos_r;
    health_s   = health_r;
    power_s    = power_r;
    dmg_out_s  = {DMG_W{1'b0}};
    cd_s       = cd_r;
    hold_s     = hold_r;

    case (state_r)
      IDLE: begin
        if (spawn_req && (spawn_type != 2'd0)) begin
          type_lat_s = spawn_type;
          state_s    = SPAWN;
        end else begin
          state_s    = IDLE;
        end
      end
      SPAWN: begin
        health_s = {HP_W{1'b1}};
        power_s  = power_f(type_lat_r);
        pos_s    = POS_W'(START_POS);
        cd_s     = {CD_W{1'b0}};
        etype_s  = type_lat_r;
        state_s  = ALIVE;
      end
      ALIVE: begin
        // A lethal hit wins over any move or attack in the same cycle.
        if (kill_s) begin
          health_s = {HP_W{1'b0}};
          hold_s   = {HOLD_W{1'b0}};
          state_s  = DYING;
        end else begin
          if (damage_en) begin
            health_s = hp_diff_s[HP_W-1:0];
          end else begin
            health_s = health_r;
          end
          if (move_en) begin
            if (advance_s) begin
              pos_s = pos_r + POS_W'(1);
            end else if (cd_r == {CD_W{1'b0}}) begin
              dmg_out_s = power_r;
              cd_s      = CD_W'(COOLDOWN);
            end else begin
              cd_s      = cd_r - CD_W'(1);
            end
          end else begin
            pos_s = pos_r;
          end
        end
      end
      DYING: begin
        if (hold_r == HOLD_W'(DEAD_HOLD - 1)) begin
          hold_s  = {HOLD_W{1'b0}};
          etype_s = 2'd0;
          state_s = IDLE;
        end else begin
          hold_s  = hold_r + HOLD_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_enemy_unit.sv
// Directed, scoreboard-driven bench for enemy_unit: expectations are queued when
// stimulus is applied and popped against DUT outputs one cycle later.
module tb_enemy_unit;

  localparam int POS_W = 9;
  localparam int DMG_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             spawn_req;
  logic [1:0]       spawn_type;
  logic             spawn_ready;
  logic             move_en;
  logic             damage_en;
  logic [DMG_W-1:0] damage_in;
  logic [POS_W-1:0] unit_front;
  logic [POS_W-1:0] position;
  logic [DMG_W-1:0] damage_out;
  logic [1:0]       enemy_type;
  logic             alive;
  logic             dead;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model of the unit while ALIVE.
  int mpos, mcd, mpow;

  enemy_unit dut (
    .clk        (clk),
    .reset      (reset),
    .spawn_req  (spawn_req),
    .spawn_type (spawn_type),
    .spawn_ready(spawn_ready),
    .move_en    (move_en),
    .damage_en  (damage_en),
    .damage_in  (damage_in),
    .unit_front (unit_front),
    .position   (position),
    .damage_out (damage_out),
    .enemy_type (enemy_type),
    .alive      (alive),
    .dead       (dead)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_underflow: observed %0d expected none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] v);
    sb_push(tag, v);
    sb_check(obs);
  endtask

  task automatic do_spawn(input logic [1:0] t);
    spawn_req  = 1'b1;
    spawn_type = t;
    tick();
    spawn_req  = 1'b0;
    spawn_type = 2'd0;
    chk("spawn_ready_drop", 32'(spawn_ready), 32'd0);
    chk("spawn_not_alive",  32'(alive),       32'd0);
    tick();
    chk("spawn_alive",      32'(alive),       32'd1);
    chk("spawn_type",       32'(enemy_type),  32'(t));
    chk("spawn_pos",        32'(position),    32'd0);
    mpos = 0;
    mcd  = 0;
    mpow = 1 << (DMG_W - 4 + int'(t));
  endtask

  // One move tick with optional non-lethal damage; optionally checks the pulse ends.
  task automatic move_tick(input int front, input bit settle, input int dmg);
    int edmg;
    edmg = 0;
    if (mpos < front && mpos != 511) begin
      mpos++;
    end else if (mcd == 0) begin
      edmg = mpow;
      mcd  = 4;
    end else begin
      mcd--;
    end
    sb_push("move_pos", 32'(mpos));
    sb_push("move_dmg", 32'(edmg));
    unit_front = POS_W'(front);
    damage_en  = (dmg != 0);
    damage_in  = DMG_W'(dmg);
    move_en    = 1'b1;
    tick();
    move_en    = 1'b0;
    damage_en  = 1'b0;
    damage_in  = '0;
    sb_check(32'(position));
    sb_check(32'(damage_out));
    if (settle) begin
      sb_push("pulse_end", 32'd0);
      tick();
      sb_check(32'(damage_out));
    end
  endtask

  task automatic hit(input int dmg);
    damage_en = 1'b1;
    damage_in = DMG_W'(dmg);
    tick();
    damage_en = 1'b0;
    damage_in = '0;
  endtask

  initial begin
    reset      = 1'b1;
    spawn_req  = 1'b0;
    spawn_type = 2'd0;
    move_en    = 1'b0;
    damage_en  = 1'b0;
    damage_in  = '0;
    unit_front = '0;
    mpos = 0; mcd = 0; mpow = 0;
    #2;
    chk("rst_ready", 32'(spawn_ready), 32'd1);
    chk("rst_alive", 32'(alive),       32'd0);
    chk("rst_dead",  32'(dead),        32'd0);
    chk("rst_type",  32'(enemy_type),  32'd0);
    chk("rst_pos",   32'(position),    32'd0);
    chk("rst_dmg",   32'(damage_out),  32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Spawn type 2, advance to front 3, then attack on cooldown.
    do_spawn(2'd2);
    for (int k = 0; k < 12; k++) move_tick(3, 1'b1, 0);

    // Advance to 7, attack, then reset between edges.
    for (int k = 0; k < 5; k++) move_tick(7, 1'b1, 0);
    move_tick(7, 1'b0, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_pos",   32'(position),    32'd0);
    chk("mid_rst_dmg",   32'(damage_out),  32'd0);
    chk("mid_rst_alive", 32'(alive),       32'd0);
    chk("mid_rst_type",  32'(enemy_type),  32'd0);
    chk("mid_rst_ready", 32'(spawn_ready), 32'd1);
    tick();
    reset = 1'b0;

    // Type 1: blocked at once, damage, death and hold.
    do_spawn(2'd1);
    move_tick(0, 1'b1, 0);
    hit(100);
    chk("hp_after_100", 32'(alive), 32'd1);
    hit(100);
    chk("hp_after_200", 32'(alive), 32'd1);
    hit(55);
    chk("kill_dead",  32'(dead),  32'd1);
    chk("kill_alive", 32'(alive), 32'd0);
    for (int i = 1; i < 10; i++) begin
      if (i <= 5) begin
        spawn_req  = 1'b1;
        spawn_type = 2'd3;
        move_en    = 1'b1;
        damage_en  = 1'b1;
        damage_in  = 8'd200;
      end else begin
        spawn_req  = 1'b0;
        spawn_type = 2'd0;
        move_en    = 1'b0;
        damage_en  = 1'b0;
        damage_in  = '0;
      end
      tick();
      chk("dying_dead", 32'(dead),       32'd1);
      chk("dying_type", 32'(enemy_type), 32'd1);
    end
    chk("dying_pos", 32'(position), 32'd0);
    tick();
    chk("idle_dead",  32'(dead),        32'd0);
    chk("idle_ready", 32'(spawn_ready), 32'd1);
    chk("idle_type",  32'(enemy_type),  32'd0);

    // Type 0 request is ignored.
    spawn_req  = 1'b1;
    spawn_type = 2'd0;
    tick();
    spawn_req  = 1'b0;
    chk("type0_ready", 32'(spawn_ready), 32'd1);
    chk("type0_alive", 32'(alive),       32'd0);

    // Type 3: damage alongside a move, then a lethal hit that pre-empts the move.
    do_spawn(2'd3);
    for (int k = 0; k < 4; k++) move_tick(9, 1'b1, 0);
    move_tick(9, 1'b1, 254);
    chk("hp_254_alive", 32'(alive), 32'd1);
    unit_front = 9'd9;
    move_en    = 1'b1;
    hit(1);
    move_en    = 1'b0;
    chk("prio_pos",  32'(position),   32'd5);
    chk("prio_dmg",  32'(damage_out), 32'd0);
    chk("prio_dead", 32'(dead),       32'd1);

    // Reset aborts the dying hold.
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("dying_rst_dead",  32'(dead),        32'd0);
    chk("dying_rst_ready", 32'(spawn_ready), 32'd1);
    chk("dying_rst_pos",   32'(position),    32'd0);
    chk("dying_rst_type",  32'(enemy_type),  32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 32'(spawn_ready), 32'd1);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/enemy_unit.md
ENEMY_UNIT -- requirements
Module: enemy_unit

Interface
REQ-001 SHALL have parameter POS_W, default 9, position width in bits.
REQ-002 SHALL have parameter DMG_W, default 8, damage and power width (DMG_W >= 4).
REQ-003 SHALL have parameter HP_W, default 8, health width.
REQ-004 SHALL have parameter COOLDOWN, default 4, blocked move ticks skipped between attacks.
REQ-005 SHALL have parameter DEAD_HOLD, default 10, clock cycles spent in DYING.
REQ-006 SHALL have parameter START_POS, default 0, spawn position.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-009 SHALL have port spawn_req, input, 1, spawn request.
REQ-010 SHALL have port spawn_type, input, 2, requested type; 0 = none.
REQ-011 SHALL have port spawn_ready, output, 1, high when a spawn can be accepted.
REQ-012 SHALL have port move_en, input, 1, single-cycle game tick enabling move or attack.
REQ-013 SHALL have port damage_en, input, 1, qualifies damage_in.
REQ-014 SHALL have port damage_in, input, DMG_W, incoming damage.
REQ-015 SHALL have port unit_front, input, POS_W, position of the frontmost opposing unit.
REQ-016 SHALL have port position, output, POS_W, current position.
REQ-017 SHALL have port damage_out, output, DMG_W, attack damage, one-cycle pulse.
REQ-018 SHALL have port enemy_type, output, 2, active type; 0 = none.
REQ-019 SHALL have port alive, output, 1, high in ALIVE.
REQ-020 SHALL have port dead, output, 1, high in DYING.

Function
REQ-021 SHALL implement states IDLE, SPAWN, ALIVE and DYING; no other state is reachable.
REQ-022 SHALL drive spawn_ready high only in IDLE; a spawn is accepted when spawn_req, spawn_ready and spawn_type != 0 are all high at a clock edge, moving IDLE to SPAWN and latching spawn_type.
REQ-023 SHALL ignore spawn_req with spawn_type 0, and spawn_req in any state other than IDLE.
REQ-024 SHALL, in SPAWN (exactly one cycle), load health to all-ones, power to 2^(DMG_W-4+type), position to START_POS, cooldown counter to 0 and enemy_type to the latched type, then go to ALIVE.
REQ-025 SHALL drive damage_out to 0 in every cycle except an attack cycle.
REQ-026 SHALL, in ALIVE with damage_en and damage_in >= health, set health to 0 and go to DYING; move_en is ignored in that cycle.
REQ-027 SHALL, in ALIVE with damage_en and damage_in < health, subtract damage_in from health.
REQ-028 SHALL, in ALIVE with move_en and no kill, add 1 to position when position < unit_front and position != 2^POS_W-1 (advance); the cooldown counter is unchanged.
REQ-029 SHALL treat move_en without advance as blocked: if the cooldown counter is 0, drive damage_out = power for one cycle and load COOLDOWN; otherwise decrement the counter.
REQ-030 SHALL allow damage and move or attack in the same cycle when the damage does not kill.
REQ-031 SHALL hold position, health and enemy_type in DYING for DEAD_HOLD cycles, then enter IDLE with enemy_type = 0.
REQ-032 SHALL ignore damage_en and move_en in IDLE, SPAWN and DYING.

Reset
REQ-033 SHALL, while reset is high, force the following immediately: state IDLE, position = START_POS, damage_out = 0, enemy_type = 0, health = 0, alive = 0, dead = 0, counters = 0.
REQ-034 SHALL abort any state on reset, including ALIVE and DYING mid-hold.

Verification
REQ-035 SHALL verify spawn: reset, then spawn_req with type 2 -> spawn_ready drops; next cycle SPAWN; the following cycle alive=1, enemy_type=2, position=0, power=64.
REQ-036 SHALL verify move and attack: unit_front=3 and 12 move_en ticks -> position 1,2,3; damage_out=64 on blocked ticks 1 and 6 only.
REQ-037 SHALL verify damage: type 1, damage 100 twice -> health 55; then damage 55 -> dead=1 for 10 cycles, then IDLE, enemy_type=0, spawn_ready=1.
REQ-038 SHALL verify kill priority: lethal damage with move_en in the same cycle, position=5 and unit_front=9 -> position stays 5 and damage_out=0.
REQ-039 SHALL verify ignored spawns: spawn_type 0 in IDLE, and type 3 during DYING -> no state change.
REQ-040 SHALL verify reset mid-operation: reset asserted in ALIVE at position 7 -> outputs at reset values before the next clock edge.
